// File: rtl/dtcm_pkg.sv
// Shared types and constants for the dtcm request/response controller.
package dtcm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAP,
        WR_ISSUE,
        RMW_RD,
        RMW_WR,
        ERR,
        RESP
    } dtcm_state_t;

    localparam int unsigned DTCM_BE_WIDTH = 4;
    localparam int unsigned BYTE_OFS      = $clog2(DTCM_BE_WIDTH);

    localparam logic [DTCM_BE_WIDTH-1:0] MASK_ONES = '1;
    localparam logic [DTCM_BE_WIDTH-1:0] MASK_ZERO = '0;

    function automatic int unsigned byte_ofs(input int unsigned be_width);
        return $clog2(be_width);
    endfunction

endpackage

// File: rtl/dtcm_byte_merge.sv
// Byte-lane merge: masked lanes take the new data, the rest keep the old word.
module dtcm_byte_merge #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic [DATA_WIDTH-1:0] i_old,
    input  logic [DATA_WIDTH-1:0] i_new,
    input  logic [BE_WIDTH-1:0]   i_mask,
    output logic [DATA_WIDTH-1:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        for (int unsigned i = 0; i < BE_WIDTH; i++) begin
            if (i_mask[i]) begin
                o_merged[8*i +: 8] = i_new[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dtcm_ctrl.sv
// Single-outstanding valid/ready front end for the dtcm RAM; partial writes
// are done as read-modify-write since the RAM has no byte enables.
module dtcm_ctrl
    import dtcm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic                                   cmd_read,
    input  logic [ADDR_WIDTH+$clog2(BE_WIDTH)-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]                  cmd_wdata,
    input  logic [BE_WIDTH-1:0]                    cmd_wmask,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [DATA_WIDTH-1:0]                  rsp_rdata,
    output logic                                   rsp_err,
    output logic [ADDR_WIDTH-1:0]                  ram_addr,
    output logic [DATA_WIDTH-1:0]                  ram_wr_data,
    output logic                                   ram_wr_en,
    input  logic [DATA_WIDTH-1:0]                  ram_rd_data
);

    localparam int unsigned BOFS = byte_ofs(BE_WIDTH);

    dtcm_state_t r_state;
    dtcm_state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_WIDTH-1:0]   r_mask;

    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_mask_full;
    logic                  w_mask_zero;
    logic [ADDR_WIDTH-1:0] w_cmd_word;
    logic [DATA_WIDTH-1:0] w_merged;

    logic                  w_rsp_valid_nxt;
    logic                  w_rsp_err_nxt;
    logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
    logic [ADDR_WIDTH-1:0] w_ram_addr_nxt;
    logic [DATA_WIDTH-1:0] w_ram_wr_data_nxt;
    logic                  w_ram_wr_en_nxt;

    assign cmd_ready   = (r_state == IDLE);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_misalign  = |cmd_addr[BOFS-1:0];
    assign w_mask_full = (cmd_wmask == '1);
    assign w_mask_zero = (cmd_wmask == '0);
    assign w_cmd_word  = cmd_addr[ADDR_WIDTH+BOFS-1:BOFS];

    dtcm_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .BE_WIDTH   (BE_WIDTH)
    ) u_merge (
        .i_old    (ram_rd_data),
        .i_new    (r_wdata),
        .i_mask   (r_mask),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misalign)       w_state_nxt = ERR;
                    else if (cmd_read)    w_state_nxt = RD_ISSUE;
                    else if (w_mask_full) w_state_nxt = WR_ISSUE;
                    else if (w_mask_zero) w_state_nxt = RESP;
                    else                  w_state_nxt = RMW_RD;
                end
            end
            RD_ISSUE: w_state_nxt = RD_CAP;
            RD_CAP:   w_state_nxt = RESP;
            WR_ISSUE: w_state_nxt = RESP;
            RMW_RD:   w_state_nxt = RMW_WR;
            RMW_WR:   w_state_nxt = RESP;
            ERR:      w_state_nxt = RESP;
            RESP: begin
                if (rsp_valid && rsp_ready) w_state_nxt = IDLE;
            end
            default:  w_state_nxt = IDLE;
        endcase
    end

    // RAM-side registers are loaded on entry to a state so the RAM sees them
    // during that state; the read word is therefore usable one cycle after accept.
    always_comb begin
        w_rsp_valid_nxt   = rsp_valid;
        w_rsp_err_nxt     = rsp_err;
        w_rsp_rdata_nxt   = rsp_rdata;
        w_ram_addr_nxt    = ram_addr;
        w_ram_wr_data_nxt = ram_wr_data;
        w_ram_wr_en_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept && !w_misalign) begin
                    if (cmd_read || !w_mask_zero) w_ram_addr_nxt = w_cmd_word;
                    if (!cmd_read && w_mask_full) begin
                        w_ram_wr_data_nxt = cmd_wdata;
                        w_ram_wr_en_nxt   = 1'b1;
                    end
                end
            end
            RD_CAP: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = ram_rd_data;
            end
            WR_ISSUE, RMW_WR: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = '0;
            end
            RMW_RD: begin
                w_ram_wr_data_nxt = w_merged;
                w_ram_wr_en_nxt   = 1'b1;
            end
            ERR: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = 1'b1;
                w_rsp_rdata_nxt = '0;
            end
            RESP: begin
                // A zero-mask write enters RESP directly and raises valid here.
                if (!rsp_valid) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end else if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
            ram_wr_en   <= 1'b0;
            r_wdata     <= '0;
            r_mask      <= '0;
        end else begin
            rsp_valid   <= w_rsp_valid_nxt;
            rsp_err     <= w_rsp_err_nxt;
            rsp_rdata   <= w_rsp_rdata_nxt;
            ram_addr    <= w_ram_addr_nxt;
            ram_wr_data <= w_ram_wr_data_nxt;
            ram_wr_en   <= w_ram_wr_en_nxt;
            if (w_accept) begin
                r_wdata <= cmd_wdata;
                r_mask  <= cmd_wmask;
            end
        end
    end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Bench for dtcm_ctrl: RAM model, word-level reference memory, directed and random commands.
module tb_dtcm_ctrl;
    import dtcm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_read = 1'b0;
    logic [14:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [12:0] ram_addr;
    logic [31:0] ram_wr_data;
    logic        ram_wr_en;
    logic [31:0] ram_rd_data;

    int          n_total = 0;
    int          n_bad   = 0;
    int          wr_count = 0;
    bit          prev_we = 1'b0;
    logic [12:0] exp_ram_addr = '0;

    logic [31:0] mem     [8192];
    bit          wrote   [8192];
    logic [31:0] ref_mem [8192];

    dtcm_ctrl #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_read    (cmd_read),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wmask   (cmd_wmask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_wr_en   (ram_wr_en),
        .ram_rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed(input logic [12:0] a);
        return ({19'b0, a} * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    function automatic logic [31:0] ram_word(input logic [12:0] a);
        return wrote[a] ? mem[a] : seed(a);
    endfunction

    // RAM: data follows the registered address; writes land at the clock edge.
    assign ram_rd_data = ram_word(ram_addr);

    always @(posedge clk) begin
        if (ram_wr_en) begin
            mem[ram_addr]   <= ram_wr_data;
            wrote[ram_addr] <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ram_wr_en) begin
            wr_count++;
            check_eq("wr_en_single_cycle", 32'(prev_we), 32'd0);
        end
        prev_we = ram_wr_en;
    end

    function automatic logic [31:0] apply_mask(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic do_cmd(input bit rd, input logic [14:0] addr, input logic [31:0] wd,
                          input logic [3:0] m, input int stall);
        logic [12:0] w;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
        int          exp_wr;
        int          wc0;
        int          lat;
        int          guard;
        w         = addr[14:BYTE_OFS];
        exp_err   = (addr[BYTE_OFS-1:0] != 0);
        exp_rdata = '0;
        exp_wr    = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (rd) begin
            exp_lat = 2;
            exp_rdata = ref_mem[w];
            exp_ram_addr = w;
        end else if (m == MASK_ONES) begin
            exp_lat = 1; exp_wr = 1;
            ref_mem[w] = wd;
            exp_ram_addr = w;
        end else if (m == MASK_ZERO) begin
            exp_lat = 1;
        end else begin
            exp_lat = 2; exp_wr = 1;
            ref_mem[w] = apply_mask(ref_mem[w], wd, m);
            exp_ram_addr = w;
        end

        @(negedge clk);
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = addr; cmd_wdata = wd; cmd_wmask = m;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        wc0 = wr_count;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check_eq("rsp_latency", 32'(lat), 32'(exp_lat));
        check_eq("rsp_rdata", rsp_rdata, exp_rdata);
        check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check_eq("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("stall_rsp_rdata", rsp_rdata, exp_rdata);
            check_eq("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check_eq("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_hs_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("ram_write_count", 32'(wr_count - wc0), 32'(exp_wr));
        check_eq("ram_word", ram_word(w), ref_mem[w]);
        check_eq("ram_addr_held", 32'(ram_addr), 32'(exp_ram_addr));
    endtask

    // Partial write interrupted by reset: late=1 hits RMW_WR, late=0 hits RMW_RD.
    task automatic rmw_reset(input bit late, input logic [14:0] addr, input logic [31:0] wd,
                             input logic [3:0] m);
        logic [12:0] w;
        w = addr[14:BYTE_OFS];
        if (late) ref_mem[w] = apply_mask(ref_mem[w], wd, m);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = addr; cmd_wdata = wd; cmd_wmask = m;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        if (late) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_ram_addr = '0;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
        check_eq("rst_ram_word", ram_word(w), ref_mem[w]);
        do_cmd(1'b1, addr, '0, '0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [12:0] w;
        logic [1:0]  ofs;
        logic [3:0]  m;
        int          k;

        for (int i = 0; i < 8192; i++) ref_mem[i] = seed(13'(i));

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("reset_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("reset_ram_addr", 32'(ram_addr), 32'd0);
        check_eq("reset_ram_wr_data", ram_wr_data, 32'd0);
        check_eq("reset_ram_wr_en", 32'(ram_wr_en), 32'd0);
        rst = 1'b0;

        do_cmd(1'b0, 15'h0010, 32'hDEADBEEF, 4'hF, 0);
        check_eq("full_write_word4", ram_word(13'h004), 32'hDEADBEEF);
        do_cmd(1'b1, 15'h0010, '0, '0, 0);

        do_cmd(1'b0, 15'h0010, 32'h11223344, 4'hF, 0);
        do_cmd(1'b0, 15'h0010, 32'hAABBCCDD, 4'b0101, 0);
        check_eq("rmw_word4", ram_word(13'h004), 32'h11BB33DD);
        do_cmd(1'b1, 15'h0010, '0, '0, 0);

        do_cmd(1'b0, 15'h0012, 32'hFFFFFFFF, 4'hF, 0);
        do_cmd(1'b1, 15'h0001, '0, '0, 0);
        check_eq("misalign_word4_kept", ram_word(13'h004), 32'h11BB33DD);

        do_cmd(1'b0, 15'h0020, 32'h12345678, 4'h0, 0);
        do_cmd(1'b1, 15'h0010, '0, '0, 10);
        do_cmd(1'b1, 15'h7FFC, '0, '0, 0);
        do_cmd(1'b0, 15'h7FFC, 32'hCAFEF00D, 4'b1000, 1);

        rmw_reset(1'b1, 15'h0030, 32'hA5A5A5A5, 4'b0011);
        rmw_reset(1'b0, 15'h0034, 32'h5A5A5A5A, 4'b1100);

        for (int n = 0; n < 300; n++) begin
            w   = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(8190, 8191))
                                              : 13'($urandom_range(0, 15));
            ofs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            k   = $urandom_range(0, 5);
            m   = (k == 0) ? MASK_ONES : (k == 1) ? MASK_ZERO : 4'($urandom);
            do_cmd(bit'($urandom_range(0, 1)), {w, ofs}, $urandom, m, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
